// File: rtl/periph_obi_arbiter.sv
// Round-robin arbiter sharing one single-outstanding OBI slave port among NHARTS masters.
// Latency: grant 0 cycles after s_gnt_i, response 0 cycles after s_rvalid_i; max 1 transaction per 2 cycles.
// Backpressure: a master stays ungranted until the slave grants; a stalled winner is locked until granted or it drops req.
// Optional feature macro: PERIPH_ARB_TIMEOUT_EN (response watchdog with TIMEOUT_CYCLES limit).
module periph_obi_arbiter #(
    parameter int NHARTS         = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NHARTS-1:0]              m_req_i,
    input  logic [NHARTS-1:0]              m_we_i,
    input  logic [NHARTS*ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NHARTS*DATA_WIDTH-1:0]   m_wdata_i,
    input  logic [NHARTS*DATA_WIDTH/8-1:0] m_be_i,
    output logic [NHARTS-1:0]              m_gnt_o,
    output logic [NHARTS-1:0]              m_rvalid_o,
    output logic [DATA_WIDTH-1:0]          m_rdata_o,
    output logic                           s_req_o,
    output logic                           s_we_o,
    output logic [ADDR_WIDTH-1:0]          s_addr_o,
    output logic [DATA_WIDTH-1:0]          s_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        s_be_o,
    input  logic                           s_gnt_i,
    input  logic                           s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]          s_rdata_i,
    output logic                           timeout_o
);
    localparam int PTR_W = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;

    if (NHARTS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("periph_obi_arbiter: NHARTS must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, LOCK, BUSY} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   lock;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   scan_idx;
    int                 idx;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NHARTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef PERIPH_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;
    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    // Round-robin pick: first requesting master starting at rr_ptr, wrapping.
    always_comb begin
        winner   = rr_ptr;
        idx      = 0;
        scan_idx = '0;
        for (int i = 0; i < NHARTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NHARTS) idx = idx - NHARTS;
            scan_idx = PTR_W'(idx);
            if (m_req_i[scan_idx]) begin
                winner = scan_idx;
                break;
            end
        end
    end

    // A stalled request keeps forwarding the locked master so the slave sees stable fields.
    assign sel = (state == LOCK) ? lock : winner;

    // Output decode; everything is forced to zero while reset is asserted.
    always_comb begin
        s_req_o    = 1'b0;
        s_we_o     = 1'b0;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        s_be_o     = '0;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        timeout_o  = 1'b0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    s_req_o = |m_req_i;
                    if (s_req_o && s_gnt_i) m_gnt_o[winner] = 1'b1;
                end
                LOCK: begin
                    s_req_o = m_req_i[lock];
                    if (s_req_o && s_gnt_i) m_gnt_o[lock] = 1'b1;
                end
                BUSY: begin
                    if (s_rvalid_i) begin
                        m_rvalid_o[owner] = 1'b1;
                        m_rdata_o         = s_rdata_i;
                    end
`ifdef PERIPH_ARB_TIMEOUT_EN
                    else if (wd_expire) begin
                        m_rvalid_o[owner] = 1'b1;
                        m_rdata_o         = DATA_WIDTH'(TIMEOUT_DATA);
                        timeout_o         = 1'b1;
                    end
`endif
                end
                default: ;
            endcase
            if (s_req_o) begin
                s_we_o    = m_we_i[sel];
                s_addr_o  = m_addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                s_wdata_o = m_wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                s_be_o    = m_be_i[int'(sel)*BE_W +: BE_W];
            end
        end
    end

    // Arbitration FSM: pick, optionally hold for grant, then wait for the single response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            lock   <= '0;
`ifdef PERIPH_ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|m_req_i) begin
                        if (s_gnt_i) begin
                            owner  <= winner;
                            rr_ptr <= next_ptr(winner);
                            state  <= BUSY;
`ifdef PERIPH_ARB_TIMEOUT_EN
                            wd_cnt <= '0;
`endif
                        end else begin
                            lock  <= winner;
                            state <= LOCK;
                        end
                    end
                end
                LOCK: begin
                    if (!m_req_i[lock]) begin
                        state <= IDLE;
                    end else if (s_gnt_i) begin
                        owner  <= lock;
                        rr_ptr <= next_ptr(lock);
                        state  <= BUSY;
`ifdef PERIPH_ARB_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (s_rvalid_i) begin
                        state <= IDLE;
                    end
`ifdef PERIPH_ARB_TIMEOUT_EN
                    else if (wd_expire) begin
                        state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_obi_arbiter.sv
module tb_periph_obi_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  m_req;
    logic [2:0]  m_we;
    logic [95:0] m_addr;
    logic [95:0] m_wdata;
    logic [11:0] m_be;
    logic [2:0]  m_gnt;
    logic [2:0]  m_rvalid;
    logic [31:0] m_rdata;
    logic        s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;
    logic        s_gnt;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    periph_obi_arbiter #(
        .NHARTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_be_i(m_be),
        .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_be_o(s_be),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .timeout_o(timeout)
    );

    // Fixed per-hart request fields: hart h uses addr 0x100*(h+1).
    localparam logic [2:0] WE_BITS = 3'b101;
    logic [31:0] hart_addr  [3] = '{32'h100, 32'h200, 32'h300};
    logic [31:0] hart_wdata [3] = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hC2C2_2222};
    logic [3:0]  hart_be    [3] = '{4'h1, 4'h3, 4'hF};

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic [2:0]  e_gnt;
        logic [2:0]  e_rv;
        logic [31:0] e_rdata;
        logic        e_sreq;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] req, input logic g, input logic rv,
                       input logic [31:0] rd, input logic [2:0] eg, input logic [2:0] erv,
                       input logic [31:0] erd, input logic esr, input logic [31:0] ea);
        vec_t v;
        v.rst = r; v.req = req; v.gnt = g; v.rv = rv; v.rdata = rd;
        v.e_gnt = eg; v.e_rv = erv; v.e_rdata = erd; v.e_sreq = esr; v.e_addr = ea;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [2:0] req, input logic g, input logic rv,
                         input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst = r; m_req = req; s_gnt = g; s_rvalid = rv; s_rdata = rd;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        m_we = WE_BITS;
        for (int h = 0; h < 3; h++) begin
            m_addr[h*32 +: 32]  = hart_addr[h];
            m_wdata[h*32 +: 32] = hart_wdata[h];
            m_be[h*4 +: 4]      = hart_be[h];
        end

        //   rst req    gnt rv rdata          e_gnt  e_rv   e_rdata        sreq addr
        // reset: outputs forced to zero despite active inputs
        add(1, 3'b111, 1, 1, 32'h1234_5678, 3'b000, 3'b000, 32'h0,         0, 32'h0);
        // single master
        add(0, 3'b001, 1, 0, 32'h0,         3'b001, 3'b000, 32'h0,         1, 32'h100);
        add(0, 3'b000, 0, 1, 32'hCAFE_0001, 3'b000, 3'b001, 32'hCAFE_0001, 0, 32'h0);
        // round robin from rr_ptr=0; gnt during BUSY ignored
        add(1, 3'b111, 1, 1, 32'h0,         3'b000, 3'b000, 32'h0,         0, 32'h0);
        add(0, 3'b111, 1, 0, 32'h0,         3'b001, 3'b000, 32'h0,         1, 32'h100);
        add(0, 3'b111, 1, 1, 32'h11,        3'b000, 3'b001, 32'h11,        0, 32'h0);
        add(0, 3'b111, 1, 0, 32'h0,         3'b010, 3'b000, 32'h0,         1, 32'h200);
        add(0, 3'b111, 1, 1, 32'h22,        3'b000, 3'b010, 32'h22,        0, 32'h0);
        add(0, 3'b111, 1, 0, 32'h0,         3'b100, 3'b000, 32'h0,         1, 32'h300);
        add(0, 3'b111, 1, 1, 32'h23,        3'b000, 3'b100, 32'h23,        0, 32'h0);
        add(0, 3'b111, 1, 0, 32'h0,         3'b001, 3'b000, 32'h0,         1, 32'h100);
        add(0, 3'b111, 1, 1, 32'h24,        3'b000, 3'b001, 32'h24,        0, 32'h0);
        // grant stall: hart1 locked, others arrive later
        add(0, 3'b010, 0, 0, 32'h0,         3'b000, 3'b000, 32'h0,         1, 32'h200);
        add(0, 3'b111, 0, 0, 32'h0,         3'b000, 3'b000, 32'h0,         1, 32'h200);
        add(0, 3'b111, 0, 0, 32'h0,         3'b000, 3'b000, 32'h0,         1, 32'h200);
        add(0, 3'b111, 1, 0, 32'h0,         3'b010, 3'b000, 32'h0,         1, 32'h200);
        add(0, 3'b111, 0, 1, 32'h33,        3'b000, 3'b010, 32'h33,        0, 32'h0);
        add(0, 3'b111, 1, 0, 32'h0,         3'b100, 3'b000, 32'h0,         1, 32'h300);
        add(0, 3'b000, 0, 1, 32'h44,        3'b000, 3'b100, 32'h44,        0, 32'h0);
        // ordering: rvalid in IDLE dropped, gnt in BUSY ignored
        add(0, 3'b000, 0, 1, 32'h55,        3'b000, 3'b000, 32'h0,         0, 32'h0);
        add(0, 3'b001, 1, 0, 32'h0,         3'b001, 3'b000, 32'h0,         1, 32'h100);
        add(0, 3'b001, 1, 0, 32'h0,         3'b000, 3'b000, 32'h0,         0, 32'h0);
        add(0, 3'b000, 0, 1, 32'h66,        3'b000, 3'b001, 32'h66,        0, 32'h0);
        // lock on hart2, then it drops req: back to IDLE without grant
        add(0, 3'b100, 0, 0, 32'h0,         3'b000, 3'b000, 32'h0,         1, 32'h300);
        add(0, 3'b001, 1, 0, 32'h0,         3'b000, 3'b000, 32'h0,         0, 32'h0);
        add(0, 3'b001, 1, 0, 32'h0,         3'b001, 3'b000, 32'h0,         1, 32'h100);
        // reset while BUSY, stale rvalid dropped, rr_ptr back to 0
        add(1, 3'b000, 0, 0, 32'h0,         3'b000, 3'b000, 32'h0,         0, 32'h0);
        add(0, 3'b000, 0, 1, 32'h77,        3'b000, 3'b000, 32'h0,         0, 32'h0);
        add(0, 3'b111, 1, 0, 32'h0,         3'b001, 3'b000, 32'h0,         1, 32'h100);
        add(0, 3'b000, 0, 1, 32'h88,        3'b000, 3'b001, 32'h88,        0, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            int h;
            drive(tbl[i].rst, tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
            check($sformatf("row%0d m_gnt", i),    {29'd0, m_gnt},    {29'd0, tbl[i].e_gnt});
            check($sformatf("row%0d m_rvalid", i), {29'd0, m_rvalid}, {29'd0, tbl[i].e_rv});
            check($sformatf("row%0d m_rdata", i),  m_rdata,           tbl[i].e_rdata);
            check($sformatf("row%0d s_req", i),    {31'd0, s_req},    {31'd0, tbl[i].e_sreq});
            check($sformatf("row%0d s_addr", i),   s_addr,            tbl[i].e_addr);
            check($sformatf("row%0d timeout", i),  {31'd0, timeout},  32'd0);
            if (tbl[i].e_sreq) begin
                h = int'(tbl[i].e_addr >> 8) - 1;
                check($sformatf("row%0d s_wdata", i), s_wdata, hart_wdata[h]);
                check($sformatf("row%0d s_be", i),    {28'd0, s_be}, {28'd0, hart_be[h]});
                check($sformatf("row%0d s_we", i),    {31'd0, s_we}, {31'd0, WE_BITS[h]});
            end else begin
                check($sformatf("row%0d s_fields_idle", i), {s_wdata[27:0], s_be}, 32'd0);
            end
        end

`ifdef PERIPH_ARB_TIMEOUT_EN
        // watchdog expiry on the 4th BUSY cycle with no response
        drive(0, 3'b100, 1, 0, 32'h0);
        check("to_grant", {29'd0, m_gnt}, 32'd4);
        for (int c = 1; c <= 4; c++) begin
            drive(0, 3'b000, 0, 0, 32'h0);
            check($sformatf("to_cyc%0d timeout", c), {31'd0, timeout}, (c == 4) ? 32'd1 : 32'd0);
            check($sformatf("to_cyc%0d rvalid", c), {29'd0, m_rvalid}, (c == 4) ? 32'd4 : 32'd0);
            check($sformatf("to_cyc%0d rdata", c), m_rdata, (c == 4) ? 32'hDEADBEEF : 32'd0);
        end
        drive(0, 3'b000, 0, 0, 32'h0);
        check("to_after_pulse", {28'd0, timeout, m_rvalid}, 32'd0);
        // response arriving in the expiry cycle wins
        drive(0, 3'b001, 1, 0, 32'h0);
        check("race_grant", {29'd0, m_gnt}, 32'd1);
        for (int c = 1; c <= 3; c++) drive(0, 3'b000, 0, 0, 32'h0);
        drive(0, 3'b000, 0, 1, 32'h99);
        check("race_rvalid", {29'd0, m_rvalid}, 32'd1);
        check("race_rdata", m_rdata, 32'h99);
        check("race_timeout", {31'd0, timeout}, 32'd0);
`else
        // without the watchdog BUSY waits indefinitely
        begin
            int bad;
            bad = 0;
            drive(0, 3'b001, 1, 0, 32'h0);
            check("long_grant", {29'd0, m_gnt}, 32'd1);
            for (int c = 0; c < 300; c++) begin
                drive(0, 3'b011, 1, 0, 32'h0);
                if (m_gnt !== 3'b000 || m_rvalid !== 3'b000 || timeout !== 1'b0 || s_req !== 1'b0) bad++;
            end
            check("long_busy_quiet", bad, 32'd0);
            drive(0, 3'b000, 0, 1, 32'hFACE_0002);
            check("long_rvalid", {29'd0, m_rvalid}, 32'd1);
            check("long_rdata", m_rdata, 32'hFACE_0002);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
